// File: rtl/cache_req_ctrl_pkg.sv
// Shared encodings for the MEM-stage cache request controller:
// access sizes, FSM states and the alignment rule.
package cache_req_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    RMW_RD = 3'd2,
    RMW_WR = 3'd3,
    RESP   = 3'd4
  } state_e;

  // A half must sit on an even byte; a word (size 3 counts as word) on a
  // multiple of four. Bytes can never be misaligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

  // Byte and half stores cannot be written directly; they need a
  // read-modify-write of the containing word.
  function automatic logic is_sub_word(input logic [1:0] size);
    logic sub;
    case (size)
      SZ_BYTE: sub = 1'b1;
      SZ_HALF: sub = 1'b1;
      default: sub = 1'b0;
    endcase
    return sub;
  endfunction

endpackage

// File: rtl/cache_req_ctrl_mem_align.sv
// Lane selection for little-endian sub-word accesses: extracts and extends
// load data from a cache word, and merges store data into a read word.
module mem_align
  import cache_req_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word_rdata,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_data
);

  logic [31:0] byte_shift_s;
  logic [31:0] half_shift_s;
  logic [31:0] byte_mask_s;
  logic [31:0] half_mask_s;
  logic [31:0] byte_ins_s;
  logic [31:0] half_ins_s;

  // Lane shifts and masks shared by the load and store paths.
  always_comb begin
    byte_shift_s = word_rdata >> {addr_lo, 3'b000};
    half_shift_s = word_rdata >> {addr_lo[1], 4'b0000};
    byte_mask_s  = 32'h0000_00FF << {addr_lo, 3'b000};
    half_mask_s  = 32'h0000_FFFF << {addr_lo[1], 4'b0000};
    byte_ins_s   = {24'h00_0000, store_data[7:0]} << {addr_lo, 3'b000};
    half_ins_s   = {16'h0000, store_data[15:0]} << {addr_lo[1], 4'b0000};
  end

  // Load path: shift the selected lane to bit 0, then zero/sign extend.
  always_comb begin
    load_data = word_rdata;
    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & byte_shift_s[7]}}, byte_shift_s[7:0]};
      SZ_HALF: load_data = {{16{sign_ext & half_shift_s[15]}}, half_shift_s[15:0]};
      default: load_data = word_rdata;
    endcase
  end

  // Store path: replace only the addressed lane, keep the rest of the word.
  always_comb begin
    merged_data = store_data;
    case (size)
      SZ_BYTE: merged_data = (word_rdata & ~byte_mask_s) | (byte_ins_s & byte_mask_s);
      SZ_HALF: merged_data = (word_rdata & ~half_mask_s) | (half_ins_s & half_mask_s);
      default: merged_data = store_data;
    endcase
  end

endmodule

// File: rtl/cache_req_ctrl.sv
// MEM-stage cache request controller: accepts one load/store at a time,
// drives the cache CPU port (with read-modify-write for sub-word stores),
// and returns one response pulse with aligned data or a misalignment error.
module cache_req_ctrl
  import cache_req_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        cache_read_en,
  output logic        cache_write_en,
  output logic [31:0] cache_addr,
  output logic [31:0] cache_wdata,
  input  logic [31:0] cache_rdata,
  input  logic        cache_stall
);

  state_e      state_r;
  state_e      state_next_s;
  logic [31:0] addr_r;
  logic        we_r;
  logic [1:0]  size_r;
  logic        signed_r;
  logic [31:0] wdata_r;
  logic [31:0] rdata_r;
  logic        err_r;
  logic        req_mis_s;
  logic        req_sub_s;
  logic [31:0] load_s;
  logic [31:0] merged_s;

  assign req_mis_s = is_misaligned(req_size, req_addr[1:0]);
  assign req_sub_s = is_sub_word(req_size);

  mem_align u_align (
    .size        (size_r),
    .sign_ext    (signed_r),
    .addr_lo     (addr_r[1:0]),
    .word_rdata  (cache_rdata),
    .store_data  (wdata_r),
    .load_data   (load_s),
    .merged_data (merged_s)
  );

  // State register; reset forces IDLE on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; cache-facing states wait out cache_stall.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!req_valid) begin
          state_next_s = IDLE;
        end else if (req_mis_s) begin
          state_next_s = RESP;
        end else if (req_we && req_sub_s) begin
          state_next_s = RMW_RD;
        end else begin
          state_next_s = ACCESS;
        end
      end
      ACCESS:  state_next_s = cache_stall ? ACCESS : RESP;
      RMW_RD:  state_next_s = cache_stall ? RMW_RD : RMW_WR;
      RMW_WR:  state_next_s = cache_stall ? RMW_WR : RESP;
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Request latch and data capture: the request is frozen at acceptance,
  // load data is captured on the completing ACCESS edge, and the merged
  // word replaces the store data once the RMW read completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r   <= 32'h0000_0000;
      we_r     <= 1'b0;
      size_r   <= SZ_BYTE;
      signed_r <= 1'b0;
      wdata_r  <= 32'h0000_0000;
      rdata_r  <= 32'h0000_0000;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            addr_r   <= req_addr;
            we_r     <= req_we;
            size_r   <= req_size;
            signed_r <= req_signed;
            wdata_r  <= req_wdata;
            rdata_r  <= 32'h0000_0000;
            err_r    <= req_mis_s;
          end
        end
        ACCESS: begin
          if (!cache_stall && !we_r) begin
            rdata_r <= load_s;
          end
        end
        RMW_RD: begin
          if (!cache_stall) begin
            wdata_r <= merged_s;
          end
        end
        default: begin
          rdata_r <= rdata_r;
        end
      endcase
    end
  end

  // Output decode from the registered state and request latches.
  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_rdata     = 32'h0000_0000;
    resp_err       = 1'b0;
    cache_read_en  = 1'b0;
    cache_write_en = 1'b0;
    case (state_r)
      IDLE:   req_ready = 1'b1;
      ACCESS: begin
        cache_read_en  = ~we_r;
        cache_write_en = we_r;
      end
      RMW_RD: cache_read_en  = 1'b1;
      RMW_WR: cache_write_en = 1'b1;
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_r;
        resp_err   = err_r;
      end
      default: req_ready = 1'b0;
    endcase
  end

  assign cache_addr  = {addr_r[31:2], 2'b00};
  assign cache_wdata = wdata_r;

endmodule

// File: tb/tb_cache_req_ctrl.sv
// Directed bench for cache_req_ctrl with a small word-array cache model
// whose stall length is set per request.
module tb_cache_req_ctrl;
  import cache_req_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        cache_read_en;
  logic        cache_write_en;
  logic [31:0] cache_addr;
  logic [31:0] cache_wdata;
  logic [31:0] cache_rdata;
  logic        cache_stall;

  logic [31:0] mem [0:63];
  int          n_vec  = 0;
  int          n_miss = 0;
  int          en_viol = 0;
  int          r_lat;
  int          r_rd_cyc;
  int          r_wr_cyc;
  logic [31:0] r_rdata;
  logic        r_err;

  always #5 clk = ~clk;

  assign cache_rdata = mem[cache_addr[7:2]];

  cache_req_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .cache_read_en  (cache_read_en),
    .cache_write_en (cache_write_en),
    .cache_addr     (cache_addr),
    .cache_wdata    (cache_wdata),
    .cache_rdata    (cache_rdata),
    .cache_stall    (cache_stall)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Issue one request; cycle 0 is the acceptance cycle. The cache stalls
  // for 'stalls' enabled cycles before completing.
  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int stalls);
    int   rem;
    int   cyc;
    logic done;
    logic [31:0] exp_caddr;
    rem = stalls;
    r_lat = -1;
    r_rdata = 32'h0;
    r_err = 1'b0;
    r_rd_cyc = 0;
    r_wr_cyc = 0;
    done = 1'b0;
    exp_caddr = {addr[31:2], 2'b00};
    cache_stall = 1'b0;
    req_valid = 1'b1;
    req_we = we;
    req_size = size;
    req_signed = sgn;
    req_addr = addr;
    req_wdata = wdata;
    check_vec("ready_at_accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    // Drop valid and scramble the request to prove it was latched.
    req_valid = 1'b0;
    req_we = ~we;
    req_size = ~size;
    req_signed = ~sgn;
    req_addr = 32'hFFFF_FFFF;
    req_wdata = 32'h0000_0000;
    cyc = 1;
    while (!done && cyc < 100) begin
      cache_stall = (rem != 0);
      if (cache_read_en && cache_write_en) en_viol++;
      if ((cache_read_en || cache_write_en) && cache_addr !== exp_caddr) en_viol++;
      if (resp_valid) begin
        if (cache_read_en || cache_write_en) en_viol++;
        r_lat = cyc;
        r_rdata = resp_rdata;
        r_err = resp_err;
        done = 1'b1;
      end else begin
        if (cache_read_en) r_rd_cyc++;
        if (cache_write_en) r_wr_cyc++;
        if (cache_write_en && !cache_stall) mem[cache_addr[7:2]] = cache_wdata;
        if ((cache_read_en || cache_write_en) && rem > 0) rem--;
        @(posedge clk); #1;
        cyc++;
      end
    end
    check_vec("resp_seen", {31'b0, done}, 32'd1);
    cache_stall = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'd0;
    req_signed = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    cache_stall = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_vec("rst_ready", {31'b0, req_ready}, 32'd1);
    check_vec("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_vec("rst_rdata", resp_rdata, 32'h0);
    check_vec("rst_err", {31'b0, resp_err}, 32'd0);
    check_vec("rst_enables", {30'b0, cache_read_en, cache_write_en}, 32'd0);
    check_vec("rst_caddr", cache_addr, 32'h0);
    check_vec("rst_cwdata", cache_wdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Word load hit.
    mem[16] = 32'hDEAD_BEEF;
    run_req(1'b0, SZ_WORD, 1'b0, 32'h0000_0040, 32'h0, 0);
    check_vec("wload_data", r_rdata, 32'hDEAD_BEEF);
    check_vec("wload_err", {31'b0, r_err}, 32'd0);
    check_vec("wload_lat", r_lat, 32'd2);

    // Signed / unsigned byte load from lane 1.
    mem[16] = 32'h0000_8000;
    run_req(1'b0, SZ_BYTE, 1'b1, 32'h0000_0041, 32'h0, 0);
    check_vec("sbyte_data", r_rdata, 32'hFFFF_FF80);
    run_req(1'b0, SZ_BYTE, 1'b0, 32'h0000_0041, 32'h0, 0);
    check_vec("ubyte_data", r_rdata, 32'h0000_0080);

    // Half store into upper half via read-modify-write.
    mem[16] = 32'h1122_3344;
    run_req(1'b1, SZ_HALF, 1'b0, 32'h0000_0042, 32'h5555_ABCD, 0);
    check_vec("hstore_mem", mem[16], 32'hABCD_3344);
    check_vec("hstore_lat", r_lat, 32'd3);
    check_vec("hstore_rdata", r_rdata, 32'h0);

    // Word load miss, 20 stall cycles.
    run_req(1'b0, SZ_WORD, 1'b0, 32'h0000_0040, 32'h0, 20);
    check_vec("miss_lat", r_lat, 32'd22);
    check_vec("miss_rd_cycles", r_rd_cyc, 32'd21);
    check_vec("miss_data", r_rdata, 32'hABCD_3344);

    // Misaligned word access.
    run_req(1'b0, SZ_WORD, 1'b0, 32'h0000_0043, 32'h0, 0);
    check_vec("mis_err", {31'b0, r_err}, 32'd1);
    check_vec("mis_enables", r_rd_cyc + r_wr_cyc, 32'd0);
    check_vec("mis_rdata", r_rdata, 32'h0);
    check_vec("mis_lat", r_lat, 32'd1);

    // Misaligned half store.
    run_req(1'b1, SZ_HALF, 1'b0, 32'h0000_0045, 32'h1234, 0);
    check_vec("mis_half_err", {31'b0, r_err}, 32'd1);
    check_vec("mis_half_enables", r_rd_cyc + r_wr_cyc, 32'd0);

    // Half loads, signed lower and unsigned upper.
    mem[17] = 32'h1234_F00D;
    run_req(1'b0, SZ_HALF, 1'b1, 32'h0000_0044, 32'h0, 0);
    check_vec("shalf_data", r_rdata, 32'hFFFF_F00D);
    run_req(1'b0, SZ_HALF, 1'b0, 32'h0000_0046, 32'h0, 0);
    check_vec("uhalf_data", r_rdata, 32'h0000_1234);

    // Byte store to lane 3 with a stall on the read.
    run_req(1'b1, SZ_BYTE, 1'b0, 32'h0000_0047, 32'hFFFF_FF5A, 1);
    check_vec("bstore_mem", mem[17], 32'h5A34_F00D);
    check_vec("bstore_lat", r_lat, 32'd4);

    // Word store and size-3 load treated as word.
    run_req(1'b1, SZ_WORD, 1'b0, 32'h0000_0050, 32'hCAFE_F00D, 0);
    check_vec("wstore_mem", mem[20], 32'hCAFE_F00D);
    check_vec("wstore_lat", r_lat, 32'd2);
    run_req(1'b0, 2'd3, 1'b1, 32'h0000_0050, 32'h0, 0);
    check_vec("size3_data", r_rdata, 32'hCAFE_F00D);

    // Reset while in RMW_WR with the write stalled.
    mem[18] = 32'h1122_3344;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_size = SZ_HALF;
    req_signed = 1'b0;
    req_addr = 32'h0000_0048;
    req_wdata = 32'h0000_9999;
    cache_stall = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_vec("rmw_rd_en", {31'b0, cache_read_en}, 32'd1);
    @(posedge clk); #1;
    check_vec("rmw_wr_en", {31'b0, cache_write_en}, 32'd1);
    cache_stall = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cache_stall = 1'b0;
    check_vec("rstmid_wr_en", {31'b0, cache_write_en}, 32'd0);
    check_vec("rstmid_resp", {31'b0, resp_valid}, 32'd0);
    check_vec("rstmid_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    check_vec("rstmid_resp2", {31'b0, resp_valid}, 32'd0);
    check_vec("rstmid_en2", {30'b0, cache_read_en, cache_write_en}, 32'd0);
    check_vec("rstmid_mem", mem[18], 32'h1122_3344);

    check_vec("enable_rule_violations", en_viol, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
